// File: rtl/seg7_scan_mux.sv
// Four-digit multiplexed seven-segment driver; the divided scan clock is sampled as data.
// Define SEG7_LEAD_ZERO_BLANK_EN to blank leading zero digits 3..1 (digit 0 is always shown).
module seg7_scan_mux #(
   parameter int SYNC_STAGES  = 2,
   parameter int BLANK_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scan_clk,
   input  logic        en,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int CNT_W    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam int CNT_LAST = (BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } state_t;

   // With blanking disabled a tick lands directly on the next digit.
   localparam state_t TICK_DST = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;
   state_t                 r_state;
   logic [1:0]             r_idx;
   logic [CNT_W-1:0]       r_cnt;
   logic [15:0]            r_snap_val;
   logic [3:0]             r_snap_dp;
   logic [3:0]             r_an;
   logic [6:0]             r_seg;
   logic                   r_dp;

   logic                   w_tick;
   state_t                 w_state_nxt;
   logic [1:0]             w_idx_nxt;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic                   w_snap_load;
   logic [15:0]            w_snap_val_nxt;
   logic [3:0]             w_snap_dp_nxt;
   logic [3:0]             w_nib;
   logic [3:0]             w_an_nxt;
   logic [6:0]             w_seg_nxt;
   logic                   w_dp_nxt;

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         4'hF:    s = 7'h0E;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

`ifdef SEG7_LEAD_ZERO_BLANK_EN
   // A digit is a leading zero when it and every more significant nibble are zero.
   function automatic logic lead_blank(input logic [15:0] val, input logic [1:0] idx);
      logic b;
      case (idx)
         2'd1:    b = (val[15:4] == 12'h000);
         2'd2:    b = (val[15:8] == 8'h00);
         2'd3:    b = (val[15:12] == 4'h0);
         default: b = 1'b0;
      endcase
      return b;
   endfunction
`endif

   assign w_tick = r_sync[SYNC_STAGES-1] & ~r_hist;
   assign an     = r_an;
   assign seg    = r_seg;
   assign dp     = r_dp;

   // Synchronizer chain plus edge history for the scan clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_hist <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], scan_clk};
         r_hist <= r_sync[SYNC_STAGES-1];
      end
   end

   // State, digit index, blank counter and frame snapshot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_idx      <= 2'd0;
         r_cnt      <= '0;
         r_snap_val <= 16'h0000;
         r_snap_dp  <= 4'h0;
      end else begin
         r_state    <= w_state_nxt;
         r_idx      <= w_idx_nxt;
         r_cnt      <= w_cnt_nxt;
         r_snap_val <= w_snap_val_nxt;
         r_snap_dp  <= w_snap_dp_nxt;
      end
   end

   // Next-state logic; en low overrides any pending tick.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_snap_load = 1'b0;
      if (!en) begin
         w_state_nxt = ST_IDLE;
         w_idx_nxt   = 2'd0;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_idx_nxt = 2'd0;
               w_cnt_nxt = '0;
               if (w_tick) begin
                  w_snap_load = 1'b1;
                  w_state_nxt = TICK_DST;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_BLANK: begin
               if (w_tick) begin
                  w_idx_nxt   = r_idx + 2'd1;
                  w_snap_load = (r_idx == 2'd3);
                  w_cnt_nxt   = '0;
               end else if (r_cnt == CNT_W'(CNT_LAST)) begin
                  w_state_nxt = ST_DRIVE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            ST_DRIVE: begin
               if (w_tick) begin
                  w_idx_nxt   = r_idx + 2'd1;
                  w_snap_load = (r_idx == 2'd3);
                  w_cnt_nxt   = '0;
                  w_state_nxt = TICK_DST;
               end else begin
                  w_state_nxt = ST_DRIVE;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_idx_nxt   = 2'd0;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_comb begin
      w_snap_val_nxt = w_snap_load ? value : r_snap_val;
      w_snap_dp_nxt  = w_snap_load ? dp_in : r_snap_dp;
      w_nib          = w_snap_val_nxt[{w_idx_nxt, 2'b00} +: 4];
      w_an_nxt       = 4'hF;
      w_seg_nxt      = 7'h7F;
      w_dp_nxt       = 1'b1;
      if (w_state_nxt == ST_DRIVE) begin
         w_an_nxt = ~(4'b0001 << w_idx_nxt);
`ifdef SEG7_LEAD_ZERO_BLANK_EN
         if (lead_blank(w_snap_val_nxt, w_idx_nxt)) begin
            w_seg_nxt = 7'h7F;
         end else begin
            w_seg_nxt = hex7(w_nib);
         end
`else
         w_seg_nxt = hex7(w_nib);
`endif
         w_dp_nxt = ~w_snap_dp_nxt[w_idx_nxt];
      end else begin
         w_an_nxt  = 4'hF;
         w_seg_nxt = 7'h7F;
         w_dp_nxt  = 1'b1;
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_an  <= 4'hF;
         r_seg <= 7'h7F;
         r_dp  <= 1'b1;
      end else begin
         r_an  <= w_an_nxt;
         r_seg <= w_seg_nxt;
         r_dp  <= w_dp_nxt;
      end
   end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: two instances (16 blank cycles and none) checked against a
// frame-level model of ticks, digits and snapshots, plus directed scenario checks.
`timescale 1ns/1ps
module tb_seg7_scan_mux;

   localparam int BC0 = 16;
   localparam int BC1 = 0;
`ifdef SEG7_LEAD_ZERO_BLANK_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif
   localparam logic [11:0] OFF = {4'hF, 7'h7F, 1'b1};

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        en       = 1'b0;
   logic [15:0] value    = 16'h0000;
   logic [3:0]  dp_in    = 4'h0;
   logic        scan_man = 1'b0;
   logic        scan_gen = 1'b0;
   logic        scan_run = 1'b0;
   int          scan_half = 20;
   wire         scan_clk = scan_run ? scan_gen : scan_man;

   logic [3:0] an0, an1;
   logic [6:0] seg0, seg1;
   logic       dp0, dp1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [11:0] frame_seq [4] = '{{4'hE, 7'h0E, 1'b1}, {4'hD, 7'h08, 1'b1},
                                  {4'hB, 7'h24, 1'b0}, {4'h7, 7'h79, 1'b1}};

   seg7_scan_mux #(.SYNC_STAGES(2), .BLANK_CYCLES(BC0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .scan_clk(scan_clk), .en(en), .value(value),
      .dp_in(dp_in), .an(an0), .seg(seg0), .dp(dp0));

   seg7_scan_mux #(.SYNC_STAGES(2), .BLANK_CYCLES(BC1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .scan_clk(scan_clk), .en(en), .value(value),
      .dp_in(dp_in), .an(an1), .seg(seg1), .dp(dp1));

   always #5 clk = ~clk;

   // Free-running scan square wave, half period in clk cycles.
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(negedge clk);
         cnt++;
         if (cnt >= scan_half) begin
            cnt = 0;
            scan_gen = ~scan_gen;
         end
      end
   end

   // Reference model: a rise seen at edge k acts at edge k+2; each instance tracks its own frame.
   logic [2:0]  m_hist;
   logic        m_on    [2];
   int          m_digit [2];
   int          m_blank [2];
   logic [15:0] m_val   [2];
   logic [3:0]  m_dp    [2];
   wire         m_tick = m_hist[1] & ~m_hist[2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_hist <= 3'b000;
         for (int d = 0; d < 2; d++) begin
            m_on[d] <= 1'b0; m_digit[d] <= 0; m_blank[d] <= 0;
            m_val[d] <= 16'h0000; m_dp[d] <= 4'h0;
         end
      end else begin
         m_hist <= {m_hist[1:0], scan_clk};
         for (int d = 0; d < 2; d++) begin
            if (!en) begin
               m_on[d] <= 1'b0; m_digit[d] <= 0; m_blank[d] <= 0;
            end else if (m_tick) begin
               if (!m_on[d] || m_digit[d] == 3) begin
                  m_val[d] <= value; m_dp[d] <= dp_in;
               end
               m_digit[d] <= m_on[d] ? (m_digit[d] + 1) % 4 : 0;
               m_on[d]    <= 1'b1;
               m_blank[d] <= (d == 0) ? BC0 : BC1;
            end else if (m_blank[d] > 0) begin
               m_blank[d] <= m_blank[d] - 1;
            end
         end
      end
   end

   function automatic logic [11:0] exp_out(int d);
      logic [15:0] upper;
      logic [6:0]  s;
      logic [3:0]  a;
      if (!m_on[d] || m_blank[d] != 0) return OFF;
      upper = m_val[d] >> (4 * m_digit[d]);
      s = hex_tab[upper[3:0]];
      if (LZB && m_digit[d] != 0 && upper == 16'h0000) s = 7'h7F;
      a = ~(4'b0001 << m_digit[d]);
      return {a, s, ~m_dp[d][m_digit[d]]};
   endfunction

   function automatic logic [11:0] obs(int d);
      return (d == 0) ? {an0, seg0, dp0} : {an1, seg1, dp1};
   endfunction

   task automatic wait_an(input int d, input logic [3:0] target, input int budget, output bit ok);
      logic [11:0] o;
      ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         @(negedge clk);
         o = obs(d);
         if (o[11:8] == target) ok = 1'b1;
      end
   endtask

   task automatic restart_idle();
      en = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      bit ok;
      logic [11:0] o;
      rst_n = 1'b0; en = 1'b0; scan_run = 1'b0; scan_man = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (obs(d) !== OFF) begin n_fail++; $display("FAIL reset_state dut%0d got=%h exp=%h", d, obs(d), OFF); end
      end
      rst_n = 1'b1; en = 1'b1; scan_half = 15; scan_run = 1'b1;
      wait_an(0, 4'hE, 400, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL reset_reach_drive got=timeout exp=an_E"); end
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (obs(d) !== OFF) begin n_fail++; $display("FAIL reset_async dut%0d got=%h exp=%h", d, obs(d), OFF); end
      end
      scan_run = 1'b0; scan_man = 1'b0; value = 16'h0000; dp_in = 4'h0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs(d) !== OFF) begin n_fail++; $display("FAIL reset_no_rise dut%0d got=%h exp=%h", d, obs(d), OFF); end
         end
      end
      scan_man = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs(d) !== exp_out(d)) begin n_fail++; $display("FAIL reset_first_model dut%0d c=%0d got=%h exp=%h", d, c, obs(d), exp_out(d)); end
         end
         o = obs(1);
         if (c == 2) begin
            n_checks++;
            if (o !== OFF) begin n_fail++; $display("FAIL reset_latency_early got=%h exp=%h", o, OFF); end
         end else if (c == 3) begin
            n_checks++;
            if (o !== {4'hE, 7'h40, 1'b1}) begin n_fail++; $display("FAIL reset_latency_edge got=%h exp=%h", o, {4'hE, 7'h40, 1'b1}); end
         end
      end
   endtask

   task automatic test_frame();
      logic [11:0] prev;
      logic [11:0] o;
      scan_run = 1'b0; scan_man = 1'b0;
      restart_idle();
      value = 16'h12AF; dp_in = 4'b0100; en = 1'b1;
      repeat (5) @(negedge clk);
      for (int t = 0; t < 4; t++) begin
         prev = obs(0);
         scan_man = 1'b1;
         for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 20) scan_man = 1'b0;
            o = obs(0);
            n_checks++;
            if (o !== exp_out(0)) begin n_fail++; $display("FAIL frame_model t=%0d c=%0d got=%h exp=%h", t, c, o, exp_out(0)); end
            if (c <= 2) begin
               n_checks++;
               if (o !== prev) begin n_fail++; $display("FAIL frame_latency t=%0d c=%0d got=%h exp=%h", t, c, o, prev); end
            end else if (c <= 18) begin
               n_checks++;
               if (o !== OFF) begin n_fail++; $display("FAIL frame_blank t=%0d c=%0d got=%h exp=%h", t, c, o, OFF); end
            end else if (c == 19) begin
               n_checks++;
               if (o !== frame_seq[t]) begin n_fail++; $display("FAIL frame_digit t=%0d got=%h exp=%h", t, o, frame_seq[t]); end
            end
         end
      end
   endtask

   task automatic test_tearing();
      bit ok;
      logic [11:0] o;
      logic [3:0]  tgt [4];
      logic [6:0]  want;
      tgt = '{4'hE, 4'hD, 4'hB, 4'h7};
      restart_idle();
      value = 16'h12AF; dp_in = 4'h0; scan_half = 25; scan_run = 1'b1; en = 1'b1;
      wait_an(0, 4'hB, 600, ok);
      o = obs(0);
      n_checks++;
      if (!ok || o[7:1] !== 7'h24) begin n_fail++; $display("FAIL tear_digit2 got=%h exp=%h", o[7:1], 7'h24); end
      value = 16'h0000;
      wait_an(0, 4'h7, 200, ok);
      o = obs(0);
      n_checks++;
      if (!ok || o[7:1] !== 7'h79) begin n_fail++; $display("FAIL tear_digit3 got=%h exp=%h", o[7:1], 7'h79); end
      for (int i = 0; i < 4; i++) begin
         wait_an(0, tgt[i], 200, ok);
         o = obs(0);
         want = (i == 0 || !LZB) ? 7'h40 : 7'h7F;
         n_checks++;
         if (!ok || o[7:1] !== want) begin n_fail++; $display("FAIL tear_new_frame digit=%0d got=%h exp=%h", i, o[7:1], want); end
      end
   endtask

   task automatic test_en_low();
      bit ok;
      logic [11:0] o;
      restart_idle();
      value = 16'hBEEF; dp_in = 4'b1010; scan_half = 25; scan_run = 1'b1; en = 1'b1;
      wait_an(0, 4'hD, 600, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL en_reach_drive got=timeout exp=an_D"); end
      en = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (obs(d) !== OFF) begin n_fail++; $display("FAIL en_low_off dut%0d got=%h exp=%h", d, obs(d), OFF); end
      end
      scan_man = 1'b1; scan_run = 1'b0;
      repeat (8) @(negedge clk);
      en = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (c == 10) scan_man = 1'b0;
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs(d) !== OFF) begin n_fail++; $display("FAIL en_no_fall_start dut%0d c=%0d got=%h exp=%h", d, c, obs(d), OFF); end
         end
      end
      scan_man = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs(d) !== exp_out(d)) begin n_fail++; $display("FAIL en_resume_model dut%0d c=%0d got=%h exp=%h", d, c, obs(d), exp_out(d)); end
         end
         if (c == 3) begin
            o = obs(1);
            n_checks++;
            if (o !== {4'hE, 7'h0E, 1'b1}) begin n_fail++; $display("FAIL en_resume_idx0 got=%h exp=%h", o, {4'hE, 7'h0E, 1'b1}); end
         end
      end
   endtask

   task automatic test_no_blank();
      bit seen;
      logic [11:0] o;
      restart_idle();
      value = 16'($urandom); dp_in = 4'($urandom); scan_half = 6; scan_run = 1'b1; en = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (c % 50 == 49) value = 16'($urandom);
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs(d) !== exp_out(d)) begin n_fail++; $display("FAIL noblank_model dut%0d c=%0d got=%h exp=%h", d, c, obs(d), exp_out(d)); end
         end
         o = obs(1);
         if (seen) begin
            n_checks++;
            if (o[11:8] === 4'hF) begin n_fail++; $display("FAIL noblank_gap c=%0d got=%h exp=not_F", c, o[11:8]); end
         end
         if (o[11:8] !== 4'hF) seen = 1'b1;
      end
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL noblank_started got=0 exp=1"); end
   endtask

   task automatic test_lead_zero();
      bit ok;
      logic [11:0] o;
      logic [3:0]  tgt  [4];
      logic [6:0]  want [4];
      tgt  = '{4'hE, 4'hD, 4'hB, 4'h7};
      want = '{7'h40, 7'h12, (LZB ? 7'h7F : 7'h40), (LZB ? 7'h7F : 7'h40)};
      restart_idle();
      value = 16'h0050; dp_in = 4'h0; scan_half = 8; scan_run = 1'b1; en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_an(1, tgt[i], 200, ok);
         o = obs(1);
         n_checks++;
         if (!ok || o[7:1] !== want[i]) begin n_fail++; $display("FAIL lead_zero digit=%0d an_found=%0d got=%h exp=%h", i, ok, o[7:1], want[i]); end
      end
   endtask

   task automatic test_random();
      restart_idle();
      scan_run = 1'b1; en = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs(d) !== exp_out(d)) begin n_fail++; $display("FAIL random_model dut%0d c=%0d got=%h exp=%h", d, c, obs(d), exp_out(d)); end
         end
         if ($urandom_range(0, 49) == 0) value = 16'($urandom);
         if ($urandom_range(0, 49) == 0) dp_in = 4'($urandom);
         if ($urandom_range(0, 299) == 0) en = ~en;
         else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
         if ($urandom_range(0, 399) == 0) scan_half = $urandom_range(5, 40);
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_tearing();
      test_en_low();
      test_no_blank();
      test_lead_zero();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "bench watchdog expired");
   end

endmodule
